// File: rtl/tlb_arbiter_pkg.sv
// Shared types and defaults for the two-requester TLB arbiter.
// Holds the FSM state encoding, requester ids and the round-robin select.
package tlb_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef enum logic {
    REQ_IF  = 1'b0,
    REQ_MEM = 1'b1
  } req_id_e;

  localparam int DEFAULT_WIDTH     = 8;
  localparam int DEFAULT_TLB_DELAY = 3;
  localparam int DEFAULT_MAX_WAIT  = DEFAULT_TLB_DELAY + 4;

  // A lone requester wins outright; on a tie the one not served last wins.
  function automatic req_id_e rr_pick(input logic if_req, input logic mem_req,
                                      input req_id_e rr_last);
    req_id_e pick;
    if (if_req && mem_req) begin
      pick = (rr_last == REQ_IF) ? REQ_MEM : REQ_IF;
    end else if (mem_req) begin
      pick = REQ_MEM;
    end else begin
      pick = REQ_IF;
    end
    return pick;
  endfunction

endpackage

// File: rtl/tlb_arbiter.sv
// Arbitrates the shared TLB between instruction fetch and the memory stage,
// holding the lookup stable until a hit or a bounded timeout, then acking the owner.
module tlb_arbiter
  import tlb_arbiter_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int TLB_DELAY = DEFAULT_TLB_DELAY,
  parameter int MAX_WAIT  = TLB_DELAY + 4,
  parameter int CNT_WIDTH = $clog2(MAX_WAIT + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             if_req,
  input  logic [WIDTH-1:0] if_vpage,
  output logic             if_ack,
  output logic [WIDTH-1:0] if_ppage,
  output logic             if_exc,
  input  logic             mem_req,
  input  logic [WIDTH-1:0] mem_vpage,
  output logic             mem_ack,
  output logic [WIDTH-1:0] mem_ppage,
  output logic             mem_exc,
  output logic [WIDTH-1:0] tlb_vpage,
  output logic             tlb_valid,
  input  logic [WIDTH-1:0] tlb_ppage,
  input  logic             tlb_hit,
  input  logic             tlb_exception
);

  localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_WAIT);

  state_e               state_q, state_d;
  req_id_e              owner_q, owner_d;
  req_id_e              rr_last_q, rr_last_d;
  logic [WIDTH-1:0]     vpage_q, vpage_d;
  logic [WIDTH-1:0]     ppage_q, ppage_d;
  logic                 exc_q, exc_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 if_ack_q, if_ack_d;
  logic                 mem_ack_q, mem_ack_d;
  logic                 tlb_valid_q, tlb_valid_d;

  req_id_e              grant;
  logic                 owner_req;
  logic [CNT_WIDTH-1:0] cnt_next;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_last_d   = rr_last_q;
    vpage_d     = vpage_q;
    ppage_d     = ppage_q;
    exc_d       = exc_q;
    cnt_d       = cnt_q;
    if_ack_d    = 1'b0;
    mem_ack_d   = 1'b0;
    tlb_valid_d = tlb_valid_q;
    grant       = rr_pick(if_req, mem_req, rr_last_q);
    owner_req   = (owner_q == REQ_MEM) ? mem_req : if_req;
    cnt_next    = (cnt_q == MAX_CNT) ? cnt_q : cnt_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (if_req || mem_req) begin
          owner_d     = grant;
          vpage_d     = (grant == REQ_MEM) ? mem_vpage : if_vpage;
          cnt_d       = '0;
          tlb_valid_d = 1'b1;
          state_d     = LOOKUP;
        end
      end
      LOOKUP: begin
        // An abandoned request drops tlb_valid so the TLB restarts its fill delay.
        if (!owner_req) begin
          tlb_valid_d = 1'b0;
          state_d     = IDLE;
        end else if (tlb_hit) begin
          ppage_d     = tlb_ppage;
          exc_d       = tlb_exception;
          tlb_valid_d = 1'b0;
          if_ack_d    = (owner_q == REQ_IF);
          mem_ack_d   = (owner_q == REQ_MEM);
          state_d     = RESP;
        end else begin
          cnt_d = cnt_next;
          if (cnt_next == MAX_CNT) begin
            ppage_d     = '0;
            exc_d       = 1'b1;
            tlb_valid_d = 1'b0;
            if_ack_d    = (owner_q == REQ_IF);
            mem_ack_d   = (owner_q == REQ_MEM);
            state_d     = RESP;
          end
        end
      end
      RESP: begin
        rr_last_d = owner_q;
        state_d   = IDLE;
      end
      default: begin
        tlb_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= REQ_IF;
      rr_last_q   <= REQ_IF;
      vpage_q     <= '0;
      ppage_q     <= '0;
      exc_q       <= 1'b0;
      cnt_q       <= '0;
      if_ack_q    <= 1'b0;
      mem_ack_q   <= 1'b0;
      tlb_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_last_q   <= rr_last_d;
      vpage_q     <= vpage_d;
      ppage_q     <= ppage_d;
      exc_q       <= exc_d;
      cnt_q       <= cnt_d;
      if_ack_q    <= if_ack_d;
      mem_ack_q   <= mem_ack_d;
      tlb_valid_q <= tlb_valid_d;
    end
  end

  assign if_ack    = if_ack_q;
  assign mem_ack   = mem_ack_q;
  assign if_ppage  = ppage_q;
  assign mem_ppage = ppage_q;
  assign if_exc    = exc_q;
  assign mem_exc   = exc_q;
  assign tlb_vpage = vpage_q;
  assign tlb_valid = tlb_valid_q;

endmodule

// File: tb/tb_tlb_arbiter.sv
// Bench for tlb_arbiter: a TLB model with a fill delay, a transaction-level
// expectation schedule, and a per-cycle compare against that schedule.
module tb_tlb_arbiter;

  localparam int W  = 8;
  localparam int TD = 3;
  localparam int MW = 7;
  localparam int N  = 512;

  logic         clk = 1'b0;
  logic         reset;
  logic         if_req, mem_req;
  logic [W-1:0] if_vpage, mem_vpage;
  logic         if_ack, mem_ack, if_exc, mem_exc;
  logic [W-1:0] if_ppage, mem_ppage;
  logic [W-1:0] tlb_vpage, tlb_ppage;
  logic         tlb_valid, tlb_hit, tlb_exception;

  tlb_arbiter #(.WIDTH(W), .TLB_DELAY(TD), .MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_vpage(if_vpage), .if_ack(if_ack), .if_ppage(if_ppage), .if_exc(if_exc),
    .mem_req(mem_req), .mem_vpage(mem_vpage), .mem_ack(mem_ack), .mem_ppage(mem_ppage),
    .mem_exc(mem_exc),
    .tlb_vpage(tlb_vpage), .tlb_valid(tlb_valid), .tlb_ppage(tlb_ppage),
    .tlb_hit(tlb_hit), .tlb_exception(tlb_exception)
  );

  always #5 clk = ~clk;

  // TLB model: ppage = vpage+1, page 0 faults, a miss fills after TD held-valid cycles.
  bit resident[256];
  int hold;
  bit never_hit;

  assign tlb_hit       = !never_hit && resident[tlb_vpage];
  assign tlb_ppage     = tlb_vpage + 8'd1;
  assign tlb_exception = (tlb_vpage == 8'h00);

  always @(posedge clk) begin
    if (reset) begin
      hold <= 0;
      for (int i = 0; i < 256; i++)
        resident[i] <= (i == 8'h10 || i == 8'h30 || i == 8'h40 || i == 8'h00);
    end else if (tlb_valid) begin
      hold <= hold + 1;
      if (hold == TD - 1 && !never_hit) resident[tlb_vpage] <= 1'b1;
    end else begin
      hold <= 0;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=0x%0h required=0x%0h", nm, cyc, act, exp);
    end
  endtask

  // Expectation schedule indexed by cycle number.
  bit           exp_valid[N];
  bit           exp_if[N];
  bit           exp_mem[N];
  logic [W-1:0] exp_vp[N];
  logic [W-1:0] exp_pp[N];
  bit           exp_ex[N];
  int           rr_last_m;  // 0 = IF, 1 = MEM

  function automatic int pick(input bit i, input bit m);
    if (i && m) return (rr_last_m == 0) ? 1 : 0;
    return m ? 1 : 0;
  endfunction

  // Grant at cycle t (an IDLE cycle); returns the cycle the ack is expected in.
  function automatic int serve(input int id, input logic [W-1:0] v, input int t);
    int hit_at;
    int len;
    int a;
    logic [W-1:0] pp;
    bit ex;
    hit_at = never_hit ? 0 : (resident[v] ? 1 : TD + 1);
    if (hit_at != 0 && hit_at <= MW) begin
      len = hit_at; pp = v + 8'd1; ex = (v == 8'h00);
    end else begin
      len = MW; pp = 8'h00; ex = 1'b1;
    end
    for (int k = 1; k <= len; k++) begin
      exp_valid[t + k] = 1'b1;
      exp_vp[t + k]    = v;
    end
    a = t + len + 1;
    if (id == 1) exp_mem[a] = 1'b1; else exp_if[a] = 1'b1;
    exp_pp[a] = pp;
    exp_ex[a] = ex;
    rr_last_m = id;
    return a;
  endfunction

  function automatic void lookup_only(input logic [W-1:0] v, input int t, input int n);
    for (int k = 1; k <= n; k++) begin
      exp_valid[t + k] = 1'b1;
      exp_vp[t + k]    = v;
    end
  endfunction

  always @(negedge clk) begin
    if (cyc < N) begin
      chk("tlb_valid", {31'd0, tlb_valid}, {31'd0, exp_valid[cyc]});
      chk("if_ack", {31'd0, if_ack}, {31'd0, exp_if[cyc]});
      chk("mem_ack", {31'd0, mem_ack}, {31'd0, exp_mem[cyc]});
      chk("one_ack", {31'd0, if_ack & mem_ack}, 32'd0);
      if (exp_valid[cyc]) chk("tlb_vpage", {24'd0, tlb_vpage}, {24'd0, exp_vp[cyc]});
      if (exp_if[cyc]) begin
        chk("if_ppage", {24'd0, if_ppage}, {24'd0, exp_pp[cyc]});
        chk("if_exc", {31'd0, if_exc}, {31'd0, exp_ex[cyc]});
      end
      if (exp_mem[cyc]) begin
        chk("mem_ppage", {24'd0, mem_ppage}, {24'd0, exp_pp[cyc]});
        chk("mem_exc", {31'd0, mem_exc}, {31'd0, exp_ex[cyc]});
      end
    end
  end

  task automatic to_cycle(input int n);
    if (n < cyc) chk("schedule", cyc, n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog cycle=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t, a, a1, a2, a3, w;
    reset = 1'b1; if_req = 1'b0; mem_req = 1'b0;
    if_vpage = '0; mem_vpage = '0; never_hit = 1'b0; rr_last_m = 0;

    to_cycle(3);
    chk("rst_if_ack", {31'd0, if_ack}, 32'd0);
    chk("rst_mem_ack", {31'd0, mem_ack}, 32'd0);
    chk("rst_tlb_valid", {31'd0, tlb_valid}, 32'd0);
    chk("rst_tlb_vpage", {24'd0, tlb_vpage}, 32'd0);
    chk("rst_ppage", {16'd0, if_ppage, mem_ppage}, 32'd0);
    chk("rst_exc", {30'd0, if_exc, mem_exc}, 32'd0);
    reset = 1'b0;

    // Resident hit
    t = 5; to_cycle(t);
    mem_vpage = 8'h10; mem_req = 1'b1;
    a = serve(1, 8'h10, t);
    chk("model_hit_latency", a - t, 32'd2);
    to_cycle(a); mem_req = 1'b0;
    chk("hit_mem_ack", {31'd0, mem_ack}, 32'd1);
    chk("hit_mem_ppage", {24'd0, mem_ppage}, 32'h11);
    chk("hit_if_ack", {31'd0, if_ack}, 32'd0);

    // Miss then fill, then the same page again
    t = a + 2; to_cycle(t);
    if_vpage = 8'h20; if_req = 1'b1;
    a = serve(0, 8'h20, t);
    chk("model_miss_latency", a - t, 32'd5);
    to_cycle(a); if_req = 1'b0;
    chk("miss_if_ack", {31'd0, if_ack}, 32'd1);
    chk("miss_if_ppage", {24'd0, if_ppage}, 32'h21);
    t = a + 2; to_cycle(t);
    if_req = 1'b1;
    a = serve(0, 8'h20, t);
    chk("model_refill_latency", a - t, 32'd2);
    to_cycle(a); if_req = 1'b0;

    // Contention: MEM first, MEM re-requests at once, IF then wins the tie
    t = a + 2; to_cycle(t);
    if_vpage = 8'h30; mem_vpage = 8'h40; if_req = 1'b1; mem_req = 1'b1;
    w = pick(1'b1, 1'b1);
    chk("model_first_winner", w, 32'd1);
    a1 = serve(w, (w == 1) ? 8'h40 : 8'h30, t);
    to_cycle(a1);
    chk("cont_mem_first", {30'd0, mem_ack, if_ack}, 32'd2);
    w = pick(1'b1, 1'b1);
    chk("model_second_winner", w, 32'd0);
    a2 = serve(w, 8'h30, a1 + 1);
    chk("model_cont_gap", a2 - a1, 32'd3);
    to_cycle(a2); if_req = 1'b0;
    chk("cont_if_ppage", {24'd0, if_ppage}, 32'h31);
    a3 = serve(pick(1'b0, 1'b1), 8'h40, a2 + 1);
    to_cycle(a3); mem_req = 1'b0;
    chk("cont_mem_ppage", {24'd0, mem_ppage}, 32'h41);

    // Full TLB: timeout fault
    t = a3 + 2; to_cycle(t);
    never_hit = 1'b1; if_vpage = 8'h77; if_req = 1'b1;
    a = serve(0, 8'h77, t);
    chk("model_timeout_latency", a - t, 32'd8);
    to_cycle(a); if_req = 1'b0;
    chk("timeout_if_exc", {31'd0, if_exc}, 32'd1);
    chk("timeout_if_ppage", {24'd0, if_ppage}, 32'd0);
    to_cycle(a + 1); never_hit = 1'b0;

    // Exception page
    t = a + 3; to_cycle(t);
    mem_vpage = 8'h00; mem_req = 1'b1;
    a = serve(1, 8'h00, t);
    to_cycle(a); mem_req = 1'b0;
    chk("exc_mem_exc", {31'd0, mem_exc}, 32'd1);
    chk("exc_mem_ppage", {24'd0, mem_ppage}, 32'h01);

    // Abort two cycles into LOOKUP
    t = a + 2; to_cycle(t);
    mem_vpage = 8'h55; mem_req = 1'b1;
    lookup_only(8'h55, t, 2);
    to_cycle(t + 2); mem_req = 1'b0;
    to_cycle(t + 3);
    chk("abort_tlb_valid", {31'd0, tlb_valid}, 32'd0);
    chk("abort_mem_ack", {31'd0, mem_ack}, 32'd0);

    // Reset mid-LOOKUP with the request held across it
    t = t + 6; to_cycle(t);
    if_vpage = 8'h66; if_req = 1'b1;
    lookup_only(8'h66, t, 2);
    to_cycle(t + 2); reset = 1'b1;
    to_cycle(t + 3);
    chk("rst_mid_acks", {30'd0, if_ack, mem_ack}, 32'd0);
    chk("rst_mid_tlb_valid", {31'd0, tlb_valid}, 32'd0);
    reset = 1'b0; rr_last_m = 0;
    a = serve(0, 8'h66, t + 3);
    chk("model_regrant_latency", a - t, 32'd8);
    to_cycle(a); if_req = 1'b0;
    chk("regrant_if_ppage", {24'd0, if_ppage}, 32'h67);

    to_cycle(a + 4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tlb_arbiter.md
Name: tlb_arbiter

Overview:
- Shares the single TLB instance between two requesters: instruction fetch (IF) and the memory stage (MEM).
- Latches and selects one request, then holds the TLB lookup stable, because the TLB only fills after `valid` has been held for TLB_DELAY cycles.
- Bounds the wait with a timeout, which covers the case where the TLB is full and never fills.
- Returns the translation to the owning requester with a one-cycle ack.

Parameters:
- WIDTH, `PAGE_WIDTH, width of virtual and physical page numbers
- TLB_DELAY, `TLB_DELAY, cycles `tlb_valid` must be held before the TLB fills a miss
- MAX_WAIT, `TLB_DELAY + 4, LOOKUP cycles without a hit before a translation fault
- CNT_WIDTH, $clog2(MAX_WAIT+1), width of the wait counter

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- if_req  in  1  IF translation request, level, held until if_ack
- if_vpage  in  WIDTH  IF virtual page, stable while if_req is high
- if_ack  out  1  one-cycle pulse: IF response valid
- if_ppage  out  WIDTH  IF physical page, valid with if_ack
- if_exc  out  1  IF exception/fault, valid with if_ack
- mem_req  in  1  MEM translation request, level, held until mem_ack
- mem_vpage  in  WIDTH  MEM virtual page
- mem_ack  out  1  one-cycle pulse: MEM response valid
- mem_ppage  out  WIDTH  MEM physical page
- mem_exc  out  1  MEM exception/fault
- tlb_vpage  out  WIDTH  page presented to the TLB
- tlb_valid  out  1  lookup/fill enable to the TLB
- tlb_ppage  in  WIDTH  TLB physical page (combinational)
- tlb_hit  in  1  TLB hit (combinational)
- tlb_exception  in  1  TLB exception (combinational)

Behaviour:
- Reset values (state, outputs, registers):
  - State IDLE.
  - All acks 0; tlb_valid 0.
  - tlb_vpage 0; ppage outputs 0; exc outputs 0.
  - Wait counter 0; rr_last = IF, so MEM wins the first tie.
- States: IDLE, LOOKUP, RESP.
- IDLE:
  - If neither request is high, stay in IDLE.
  - Otherwise grant one requester. A single request is granted directly.
  - If both are high, grant the one not equal to rr_last (round-robin).
  - On grant: latch owner and vpage, clear the counter, go to LOOKUP.
- LOOKUP:
  - tlb_valid=1 and tlb_vpage=latched vpage for every cycle in this state.
  - On tlb_hit=1: register ppage=tlb_ppage and exc=tlb_exception, go to RESP.
  - Else counter++. If the counter reaches MAX_WAIT, register ppage=0 and exc=1 (fault), go to RESP.
  - If the owner's req drops: abort, go to IDLE with no ack. tlb_valid falls, which resets the TLB delay chain.
- RESP:
  - Owner's ack=1 for exactly one cycle with the registered ppage/exc.
  - tlb_valid=0, so the TLB never sees spurious fill enables.
  - Set rr_last=owner, go to IDLE.
- Signals outside LOOKUP:
  - tlb_hit and tlb_exception are ignored, since the TLB computes them combinationally on a stale vpage.
  - tlb_vpage holds its last value.
- Latency:
  - Resident page: req high at cycle 0 (IDLE), LOOKUP at cycle 1, ack at cycle 2.
  - Miss: the ack follows the TLB fill delay, no later than cycle MAX_WAIT+2.
- Non-owner requests stay pending, with no ack, until a later IDLE arbitration.
- Back-to-back: a requester may keep req high after its ack. Its new request is arbitrated in the IDLE cycle after RESP, so there is at least a 1-cycle gap.
- Only one ack is ever high per cycle. Ack is never asserted for a requester whose req is low at grant.
- The counter saturates at MAX_WAIT and cannot wrap.
- Reset in any state returns to IDLE on the next edge; any pending response is discarded (no ack).

Decomposition:
- Shared package (alongside defines.sv):
  - State enum {IDLE, LOOKUP, RESP}.
  - Requester id encoding (REQ_IF=0, REQ_MEM=1).
  - Default MAX_WAIT.
- Single module; no sub-module is warranted. The 2-way round-robin is one flop plus combinational select.

Test Plan:
All scenarios use WIDTH=8, TLB_DELAY=3, MAX_WAIT=7, with a TLB model where ppage = vpage+1.
- Resident hit: preload 0x10; mem_req with mem_vpage=0x10 at cycle 0 -> tlb_valid high in cycle 1; mem_ack in cycle 2 with mem_ppage=0x11, mem_exc=0; if_ack stays 0.
- Miss then fill: empty TLB, if_req with vpage=0x20 -> tlb_valid held continuously until the fill hit; if_ack with if_ppage=0x21 no later than cycle 9; second request for 0x20 acks in cycle 2.
- Contention: if_req(0x30) and mem_req(0x40) both high at cycle 0 -> MEM served first, IF second; repeat with both high -> order alternates (IF first).
- Full TLB / timeout: TLB model never hits -> exactly 7 LOOKUP cycles, then one ack with ppage=0, exc=1; state returns to IDLE.
- Exception page and abort: vpage=0x00 hit -> ack with exc=1. Separately, drop mem_req 2 cycles into LOOKUP -> tlb_valid falls the next cycle, no mem_ack, IDLE.
- Reset mid-LOOKUP: assert reset in LOOKUP -> next cycle all acks 0, tlb_valid 0, state IDLE; a request held across reset is re-granted after reset deasserts.
